// File: rtl/wbm_arbiter_pkg.sv
// Shared definitions for the Wishbone bus arbiter: bus widths, FSM encoding
// and the default watchdog limit.
package wbm_arbiter_pkg;

    localparam int WB_DW        = 16;
    localparam int WB_AW        = 16;
    localparam int TOUT_DEFAULT = 64;
    localparam int PTR_W        = 2;  // enough to index up to four masters

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/wbm_arbiter_if.sv
// Bundle of per-master request/response lines and the shared slave bus.
// The master modport is the arbiter's view; slave is the surrounding system.
interface wbm_arbiter_if #(
    parameter int NM = 3
);
    import wbm_arbiter_pkg::*;

    logic [NM-1:0]       m_cyc_i;
    logic [NM-1:0]       m_stb_i;
    logic [NM-1:0]       m_we_i;
    logic [2*NM-1:0]     m_sel_i;
    logic [WB_AW*NM-1:0] m_adr_i;
    logic [WB_DW*NM-1:0] m_dat_i;
    logic [NM-1:0]       m_gnt_o;
    logic [NM-1:0]       m_ack_o;
    logic [NM-1:0]       m_err_o;
    logic [WB_DW-1:0]    m_dat_o;

    logic                s_cyc_o;
    logic                s_stb_o;
    logic                s_we_o;
    logic [1:0]          s_sel_o;
    logic [WB_AW-1:0]    s_adr_o;
    logic [WB_DW-1:0]    s_dat_o;
    logic [WB_DW-1:0]    s_dat_i;
    logic                s_ack_i;

    modport master (
        input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i,
        output m_gnt_o, m_ack_o, m_err_o, m_dat_o,
               s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
    );

    modport slave (
        output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i,
        input  m_gnt_o, m_ack_o, m_err_o, m_dat_o,
               s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
    );

endinterface

// File: rtl/wbm_arb_rr.sv
// Combinational round-robin picker: first requester at or after ptr_i,
// wrapping to index 0. Output is one-hot with a valid flag.
module wbm_arb_rr
    import wbm_arbiter_pkg::*;
#(
    parameter int NM = 3
) (
    input  logic [NM-1:0]    req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NM-1:0]    pick_o,
    output logic             valid_o
);

    // First pass scans ptr..NM-1, second pass wraps around from 0.
    always_comb begin
        pick_o  = '0;
        valid_o = 1'b0;
        for (int k = 0; k < NM; k++) begin
            if (!valid_o && req_i[k] && (k >= int'(ptr_i))) begin
                pick_o[k] = 1'b1;
                valid_o   = 1'b1;
            end
        end
        for (int k = 0; k < NM; k++) begin
            if (!valid_o && req_i[k]) begin
                pick_o[k] = 1'b1;
                valid_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wbm_arbiter.sv
// Round-robin, non-pre-emptive arbiter sharing one Wishbone slave bus among NM
// masters. Define WBM_ARB_TIMEOUT_EN to add the no-ack watchdog with lockout.
module wbm_arbiter
    import wbm_arbiter_pkg::*;
#(
    parameter int NM   = 3,
    parameter int TOUT = TOUT_DEFAULT
) (
    input  logic          vm_clk_p,
    input  logic          vm_rst_n,
    wbm_arbiter_if.master bus
);

    if (NM < 2 || NM > 4 || TOUT < 4 || TOUT > 255) begin : g_bad_cfg
        $error("wbm_arbiter: NM must be 2..4 and TOUT 4..255");
    end

    arb_state_e       state_q, state_d;
    logic [NM-1:0]    gnt_q, gnt_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [NM-1:0]    elig, pick;
    logic             pick_vld;
    logic             own_cyc, own_stb;
    logic [1:0]       sel_mux;
    logic [WB_AW-1:0] adr_mux;
    logic [WB_DW-1:0] dat_mux;
    logic [PTR_W-1:0] own_nxt;

    wbm_arb_rr #(.NM(NM)) u_rr (
        .req_i  (elig),
        .ptr_i  (ptr_q),
        .pick_o (pick),
        .valid_o(pick_vld)
    );

    // gnt_q is zero outside BUSY, so the AND-OR mux also forces the idle bus to 0.
    assign own_cyc = |(gnt_q & bus.m_cyc_i);
    assign own_stb = |(gnt_q & bus.m_stb_i);

    always_comb begin
        sel_mux = '0;
        adr_mux = '0;
        dat_mux = '0;
        own_nxt = '0;
        for (int k = 0; k < NM; k++) begin
            if (gnt_q[k]) begin
                sel_mux = bus.m_sel_i[2*k +: 2];
                adr_mux = bus.m_adr_i[WB_AW*k +: WB_AW];
                dat_mux = bus.m_dat_i[WB_DW*k +: WB_DW];
                own_nxt = PTR_W'((k + 1) % NM);
            end
        end
    end

    assign bus.s_cyc_o = own_cyc;
    assign bus.s_stb_o = own_stb;
    assign bus.s_we_o  = |(gnt_q & bus.m_we_i);
    assign bus.s_sel_o = sel_mux;
    assign bus.s_adr_o = adr_mux;
    assign bus.s_dat_o = dat_mux;
    assign bus.m_dat_o = bus.s_dat_i;
    assign bus.m_ack_o = gnt_q & {NM{bus.s_ack_i}};
    assign bus.m_gnt_o = gnt_q;

`ifdef WBM_ARB_TIMEOUT_EN
    logic [7:0]    wdog_q, wdog_d;
    logic [NM-1:0] lock_q, lock_d, err_q, err_d;
    logic          wdog_hit;

    assign elig        = bus.m_cyc_i & ~lock_q;
    assign wdog_hit    = own_cyc && own_stb && !bus.s_ack_i && (wdog_q == 8'(TOUT - 1));
    assign bus.m_err_o = err_q;
`else
    assign elig        = bus.m_cyc_i;
    assign bus.m_err_o = '0;
`endif

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    gnt_d   = pick;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!own_cyc
`ifdef WBM_ARB_TIMEOUT_EN
                    || wdog_hit
`endif
                   ) begin
                    gnt_d   = '0;
                    ptr_d   = own_nxt;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
`ifdef WBM_ARB_TIMEOUT_EN
        wdog_d = wdog_q + 8'd1;
        if (!own_stb || bus.s_ack_i || state_d == ST_IDLE) begin
            wdog_d = '0;
        end
        err_d  = wdog_hit ? gnt_q : '0;
        lock_d = (lock_q & bus.m_cyc_i) | err_d;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge vm_clk_p or negedge vm_rst_n) begin
        if (!vm_rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef WBM_ARB_TIMEOUT_EN
    always_ff @(posedge vm_clk_p or negedge vm_rst_n) begin
        if (!vm_rst_n) begin
            wdog_q <= '0;
            lock_q <= '0;
            err_q  <= '0;
        end else begin
            wdog_q <= wdog_d;
            lock_q <= lock_d;
            err_q  <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_wbm_arbiter.sv
// Directed plus randomized bench for wbm_arbiter against an integer-level
// ownership model; expectations follow WBM_ARB_TIMEOUT_EN when it is defined.
module tb_wbm_arbiter;
    import wbm_arbiter_pkg::*;

    localparam int NM   = 3;
    localparam int TOUT = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wbm_arbiter_if #(.NM(NM)) bus ();

    wbm_arbiter #(.NM(NM), .TOUT(TOUT)) dut (
        .vm_clk_p(clk),
        .vm_rst_n(rst_n),
        .bus     (bus)
    );

    logic [NM-1:0] cyc, stb, we;
    logic [1:0]    sel  [NM];
    logic [15:0]   adr  [NM];
    logic [15:0]   wdat [NM];
    logic [15:0]   sdat;
    logic          sack;
    logic [NM-1:0] err_acc;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: owner index (-1 = bus free), pointer, no-ack count, lockouts.
    int            own     = -1;
    int            ptr     = 0;
    int            cnt     = 0;
    logic [NM-1:0] lock    = '0;
    logic [NM-1:0] err_exp = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        bus.m_cyc_i = cyc;
        bus.m_stb_i = stb;
        bus.m_we_i  = we;
        for (int k = 0; k < NM; k++) begin
            bus.m_sel_i[2*k +: 2]   = sel[k];
            bus.m_adr_i[16*k +: 16] = adr[k];
            bus.m_dat_i[16*k +: 16] = wdat[k];
        end
        bus.s_dat_i = sdat;
        bus.s_ack_i = sack;
    endtask

    task automatic clear_all();
        cyc  = '0;
        stb  = '0;
        we   = '0;
        sack = 1'b0;
        sdat = '0;
        for (int k = 0; k < NM; k++) begin
            sel[k]  = '0;
            adr[k]  = '0;
            wdat[k] = '0;
        end
        apply();
    endtask

    task automatic model_reset();
        own     = -1;
        ptr     = 0;
        cnt     = 0;
        lock    = '0;
        err_exp = '0;
    endtask

    task automatic model_edge();
        logic [NM-1:0] elig;
        logic [NM-1:0] new_lock;
        bit            took;
        took     = 1'b0;
        elig     = cyc & ~lock;
        new_lock = lock & cyc;
        err_exp  = '0;
        if (own < 0) begin
            for (int i = 0; i < NM; i++) begin
                int k;
                k = (ptr + i) % NM;
                if (!took && elig[k]) begin
                    own  = k;
                    took = 1'b1;
                end
            end
        end else if (!cyc[own]) begin
            ptr = (own + 1) % NM;
            own = -1;
            cnt = 0;
        end else begin
`ifdef WBM_ARB_TIMEOUT_EN
            if (stb[own] && !sack) begin
                cnt++;
                if (cnt == TOUT) begin
                    err_exp[own]  = 1'b1;
                    new_lock[own] = 1'b1;
                    ptr = (own + 1) % NM;
                    own = -1;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
`endif
        end
        lock = new_lock;
    endtask

    task automatic check_outputs();
        logic [NM-1:0] eg;
        eg = '0;
        if (own >= 0) eg[own] = 1'b1;
        check("gnt",  bus.m_gnt_o, eg);
        check("ack",  bus.m_ack_o, sack ? eg : '0);
        check("err",  bus.m_err_o, err_exp);
        check("mdat", bus.m_dat_o, sdat);
        if (own >= 0) begin
            check("scyc", bus.s_cyc_o, cyc[own]);
            check("sstb", bus.s_stb_o, stb[own]);
            check("swe",  bus.s_we_o,  we[own]);
            check("ssel", bus.s_sel_o, sel[own]);
            check("sadr", bus.s_adr_o, adr[own]);
            check("sdat", bus.s_dat_o, wdat[own]);
        end else begin
            check("scyc_idle", bus.s_cyc_o, 0);
            check("sstb_idle", bus.s_stb_o, 0);
            check("sadr_idle", bus.s_adr_o, 0);
            check("sdat_idle", bus.s_dat_o, 0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        check_outputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        clear_all();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", bus.m_gnt_o, 0);
        check_outputs();
        #2 rst_n = 1'b1;

        // Round-robin: all three request, each drops cyc after one ack.
        for (int k = 0; k < NM; k++) begin
            cyc[k] = 1'b1;
            stb[k] = 1'b1;
            adr[k] = 16'(16'h0100 * (k + 1));
        end
        apply();
        step();
        for (int j = 0; j < 4; j++) begin
            int k;
            k = j % NM;
            check($sformatf("rr_gnt%0d", j), bus.m_gnt_o, 32'(1 << k));
            sack = 1'b1;
            sdat = 16'(16'hA000 + j);
            apply();
            #1;
            check("rr_ack", bus.m_ack_o, 32'(1 << k));
            step();
            sack   = 1'b0;
            cyc[k] = 1'b0;
            stb[k] = 1'b0;
            apply();
            step();
            check("rr_dead", bus.m_gnt_o, 0);
            cyc[k] = 1'b1;
            stb[k] = 1'b1;
            apply();
            step();
        end
        clear_all();
        step();
        step();

        // Single requester on master 1, ack two clocks after the grant.
        cyc[1] = 1'b1;
        stb[1] = 1'b1;
        adr[1] = 16'h1000;
        apply();
        step();
        check("single_gnt", bus.m_gnt_o, 3'b010);
        check("single_adr", bus.s_adr_o, 16'h1000);
        step();
        step();
        sack = 1'b1;
        apply();
        #1;
        check("single_ack", bus.m_ack_o, 3'b010);
        step();
        clear_all();
        step();
        step();

        // Atomic read-then-write by master 0 while master 2 waits.
        cyc[0] = 1'b1;
        stb[0] = 1'b1;
        adr[0] = 16'h2000;
        apply();
        step();
        check("atom_gnt0", bus.m_gnt_o, 3'b001);
        cyc[2] = 1'b1;
        stb[2] = 1'b1;
        adr[2] = 16'h2222;
        apply();
        step();
        sack = 1'b1;
        apply();
        step();
        sack    = 1'b0;
        we[0]   = 1'b1;
        wdat[0] = 16'h5A5A;
        apply();
        step();
        sack = 1'b1;
        apply();
        step();
        sack   = 1'b0;
        stb[0] = 1'b0;
        apply();
        step();
        check("atom_hold", bus.m_gnt_o, 3'b001);
        cyc[0] = 1'b0;
        we[0]  = 1'b0;
        apply();
        step();
        check("atom_rel", bus.m_gnt_o, 0);
        step();
        check("atom_gnt2", bus.m_gnt_o, 3'b100);
        clear_all();
        step();
        step();

        // Master 2 strobes an address nobody acknowledges.
        cyc[2] = 1'b1;
        stb[2] = 1'b1;
        adr[2] = 16'h7000;
        apply();
        step();
        check("to_gnt", bus.m_gnt_o, 3'b100);
`ifdef WBM_ARB_TIMEOUT_EN
        for (int i = 1; i <= TOUT; i++) begin
            step();
            check("to_err",  bus.m_err_o, (i == TOUT) ? 3'b100 : 3'b000);
            check("to_held", bus.m_gnt_o, (i == TOUT) ? 3'b000 : 3'b100);
        end
        step();
        check("to_err_once", bus.m_err_o, 0);
        check("to_refused",  bus.m_gnt_o, 0);
        step();
        check("to_refused2", bus.m_gnt_o, 0);
        cyc[2] = 1'b0;
        stb[2] = 1'b0;
        apply();
        step();
        cyc[2] = 1'b1;
        stb[2] = 1'b1;
        apply();
        step();
        check("to_regrant", bus.m_gnt_o, 3'b100);
`else
        err_acc = '0;
        repeat (1100) begin
            step();
            err_acc |= bus.m_err_o;
        end
        check("to_hold",  bus.m_gnt_o, 3'b100);
        check("to_noerr", err_acc, 0);
`endif
        clear_all();
        step();
        step();

        // Reset while master 1 owns the bus; pointer must restart at 0.
        cyc[0] = 1'b1;
        stb[0] = 1'b1;
        apply();
        step();
        cyc[0] = 1'b0;
        stb[0] = 1'b0;
        apply();
        step();
        cyc[1] = 1'b1;
        stb[1] = 1'b1;
        apply();
        step();
        check("pre_rst_gnt", bus.m_gnt_o, 3'b010);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_async_gnt", bus.m_gnt_o, 0);
        check("rst_async_cyc", bus.s_cyc_o, 0);
        cyc = '1;
        stb = '1;
        apply();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rst_ptr0", bus.m_gnt_o, 3'b001);
        clear_all();
        step();
        step();

        // Randomized traffic against the model.
        repeat (400) begin
            for (int k = 0; k < NM; k++) begin
                if ($urandom_range(3) == 0) cyc[k] = ~cyc[k];
                stb[k]  = cyc[k] & 1'($urandom_range(1));
                we[k]   = 1'($urandom);
                sel[k]  = 2'($urandom);
                adr[k]  = 16'($urandom);
                wdat[k] = 16'($urandom);
            end
            sack = ($urandom_range(2) == 0);
            sdat = 16'($urandom);
            apply();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
